// File: rtl/booth_radix4_multiplier.sv
// booth_radix4_multiplier
// Sequential radix-4 (modified Booth) integer multiplier. It retires two
// multiplier bits per clock and finishes in WIDTH/2+1 cycles. Each operation
// selects signed or unsigned operands. A start/busy/done handshake lets the
// block run back-to-back without a reset between operations.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   start        operation request, sampled only while idle
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   multiplicand M operand (sampled with start)
//   multiplier   Q operand (sampled with start)
//   busy         high while an operation is in progress
//   done         one-cycle pulse when product has just been updated
//   product      2*WIDTH-bit result of the last completed operation
module booth_radix4_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // Two extra bits let an unsigned all-ones operand stay positive. They also
  // make the recoding consume an even number of bits.
  localparam int N    = WIDTH + 2;
  localparam int ITER = N / 2;
  localparam int CW   = $clog2(ITER + 1);

  generate
    if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("booth_radix4_multiplier: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_next;
  logic [N:0]      acc;
  logic [N-1:0]    q_reg;
  logic            q_m1;
  logic [N:0]      mx;
  logic [CW-1:0]   count;

  logic [N-1:0]    ext_m, ext_q;
  logic [N:0]      term, sum, acc_shift;
  logic [N-1:0]    q_shift;
  logic            last;

  assign ext_m = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                             : {2'b00, multiplicand};
  assign ext_q = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier}
                             : {2'b00, multiplier};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    term       = '0;
    // Booth recoding of the overlapping triplet {Q[1],Q[0],q_m1}.
    case ({q_reg[1:0], q_m1})
      3'b001, 3'b010: term = mx;
      3'b011:         term = mx << 1;
      3'b100:         term = -(mx << 1);
      3'b101, 3'b110: term = -mx;
      default:        term = '0;
    endcase
    sum       = acc + term;
    // This is a 2-bit arithmetic shift of {S,Q,q_m1}. The sign of S is replicated into A.
    acc_shift = {sum[N], sum[N], sum[N:2]};
    q_shift   = {sum[1:0], q_reg[N-1:2]};
    last      = (count == CW'(ITER - 1));
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      q_reg   <= '0;
      q_m1    <= 1'b0;
      mx      <= '0;
      count   <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            q_reg <= ext_q;
            q_m1  <= 1'b0;
            mx    <= {ext_m[N-1], ext_m};
            count <= '0;
          end
        end
        RUN: begin
          acc   <= acc_shift;
          q_reg <= q_shift;
          q_m1  <= q_reg[1];
          count <= count + CW'(1);
          // The final iteration also publishes the low 2*WIDTH bits of the shifted {A,Q}.
          if (last) begin
            product <= {acc_shift[WIDTH-3:0], q_shift};
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// tb_booth_radix4_multiplier
// Self-checking bench for booth_radix4_multiplier. It uses a WIDTH=8 instance
// for directed corner, handshake and reset cases. It uses a WIDTH=16 instance
// for randomized operands, which are checked against a plain-arithmetic
// reference product.
module tb_booth_radix4_multiplier;

  logic        clk;
  logic        rst;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  m8, q8;
  logic [15:0] product8;

  logic        start16, sm16, busy16, done16;
  logic [15:0] m16, q16;
  logic [31:0] product16;

  int vectors;
  int errors;

  booth_radix4_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .multiplicand(m8), .multiplier(q8),
    .busy(busy8), .done(done8), .product(product8)
  );

  booth_radix4_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .multiplicand(m16), .multiplier(q16),
    .busy(busy16), .done(done16), .product(product16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference product computed with ordinary integer multiplication.
  function automatic logic [31:0] model16(input logic sm, input logic [15:0] m, input logic [15:0] q);
    longint a, b;
    if (sm) begin
      a = longint'($signed(m));
      b = longint'($signed(q));
    end else begin
      a = longint'(m);
      b = longint'(q);
    end
    return 32'(a * b);
  endfunction

  // This task starts one 8-bit operation and waits for done, with a cycle bound.
  // It scrambles the inputs during RUN. It can inject a stray start at cycle pulse_at.
  // lat counts the clock edges from the start-sampling edge to the edge where done is seen.
  task automatic applyStimulus8(input logic sm, input logic [7:0] m, input logic [7:0] q,
                                input bit immediate, input int pulse_at,
                                output int lat, output int busy_cnt, output logic [15:0] prod);
    if (!immediate) @(negedge clk);
    start8 = 1'b1; sm8 = sm; m8 = m; q8 = q;
    @(negedge clk);
    lat = 0; busy_cnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busy_cnt++;
      start8 = (lat == pulse_at);
      m8 = 8'($urandom); q8 = 8'($urandom); sm8 = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0;
    prod = product8;
  endtask

  task automatic applyStimulus16(input logic sm, input logic [15:0] m, input logic [15:0] q,
                                 output int lat, output logic [31:0] prod);
    @(negedge clk);
    start16 = 1'b1; sm16 = sm; m16 = m; q16 = q;
    @(negedge clk);
    lat = 0;
    while (!done16 && lat < 40) begin
      start16 = 1'b0;
      m16 = 16'($urandom); q16 = 16'($urandom); sm16 = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    start16 = 1'b0;
    prod = product16;
  endtask

  initial begin
    int lat, bc, extra;
    logic [15:0] p8;
    logic [31:0] p16;
    logic        sm;
    logic [15:0] a, b;

    vectors = 0; errors = 0;
    rst = 1'b0;
    start8 = 0; sm8 = 0; m8 = 0; q8 = 0;
    start16 = 0; sm16 = 0; m16 = 0; q16 = 0;

    #12;
    checkOutput("reset_busy8", {63'd0, busy8}, 64'd0);
    checkOutput("reset_done8", {63'd0, done8}, 64'd0);
    checkOutput("reset_product8", {48'd0, product8}, 64'd0);
    checkOutput("reset_busy16", {63'd0, busy16}, 64'd0);
    checkOutput("reset_product16", {32'd0, product16}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Signed -3 x 5: five-cycle latency, busy for exactly five cycles.
    applyStimulus8(1'b1, 8'hFD, 8'd5, 1'b0, -1, lat, bc, p8);
    checkOutput("s_m3x5_prod", {48'd0, p8}, 64'hFFF1);
    checkOutput("s_m3x5_lat", 64'(lat), 64'd5);
    checkOutput("s_m3x5_busy_cycles", 64'(bc), 64'd5);
    checkOutput("s_m3x5_busy_at_done", {63'd0, busy8}, 64'd0);

    applyStimulus8(1'b1, 8'h80, 8'h80, 1'b0, -1, lat, bc, p8);
    checkOutput("s_min_x_min", {48'd0, p8}, 64'h4000);
    applyStimulus8(1'b1, 8'h7F, 8'h80, 1'b0, -1, lat, bc, p8);
    checkOutput("s_max_x_min", {48'd0, p8}, 64'hC080);
    applyStimulus8(1'b0, 8'hFF, 8'hFF, 1'b0, -1, lat, bc, p8);
    checkOutput("u_ff_x_ff", {48'd0, p8}, 64'hFE01);
    applyStimulus8(1'b1, 8'hFF, 8'hFF, 1'b0, -1, lat, bc, p8);
    checkOutput("s_ff_x_ff", {48'd0, p8}, 64'h0001);

    // Back-to-back: the second start is issued in the done cycle of the first.
    applyStimulus8(1'b0, 8'd6, 8'd7, 1'b0, -1, lat, bc, p8);
    checkOutput("b2b_first_prod", {48'd0, p8}, 64'h002A);
    applyStimulus8(1'b0, 8'd9, 8'd9, 1'b1, -1, lat, bc, p8);
    checkOutput("b2b_second_prod", {48'd0, p8}, 64'h0051);
    checkOutput("b2b_second_lat", 64'(lat), 64'd5);

    // A stray start during RUN must be ignored, and no extra done may follow.
    applyStimulus8(1'b0, 8'd3, 8'd4, 1'b0, 2, lat, bc, p8);
    checkOutput("midrun_start_prod", {48'd0, p8}, 64'd12);
    checkOutput("midrun_start_lat", 64'(lat), 64'd5);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done8) extra++;
      if (i == 3) checkOutput("product_hold", {48'd0, product8}, 64'd12);
    end
    checkOutput("midrun_start_no_extra_done", 64'(extra), 64'd0);

    // Reset asserted two cycles into RUN.
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b0; m8 = 8'd10; q8 = 8'd11;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_busy", {63'd0, busy8}, 64'd0);
    checkOutput("midrst_done", {63'd0, done8}, 64'd0);
    checkOutput("midrst_product", {48'd0, product8}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus8(1'b0, 8'd10, 8'd11, 1'b0, -1, lat, bc, p8);
    checkOutput("after_rst_prod", {48'd0, p8}, 64'd110);
    checkOutput("after_rst_lat", 64'(lat), 64'd5);

    // Randomized WIDTH=16: 1000 unsigned then 1000 signed operations.
    for (int i = 0; i < 2000; i++) begin
      sm = (i >= 1000);
      a = 16'($urandom);
      b = 16'($urandom);
      case (i % 250)
        0: begin a = 16'h8000; b = 16'h8000; end
        1: begin a = 16'hFFFF; b = 16'hFFFF; end
        2: begin a = 16'h7FFF; b = 16'h8000; end
        3: begin a = 16'h0000; b = 16'hFFFF; end
        default: ;
      endcase
      applyStimulus16(sm, a, b, lat, p16);
      checkOutput("rand_prod", {32'd0, p16}, {32'd0, model16(sm, a, b)});
      checkOutput("rand_lat", 64'(lat), 64'd9);
      @(negedge clk);
      checkOutput("rand_single_done", {63'd0, done16}, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
